word_serializer: RTL and testbench
==================================

WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have one clock and synchronous, active-low reset; ports listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock, all state updates.
REQ-003 rst  input  1  synchronous, active-low reset (0 = reset).
REQ-004 E  input  1  start request, sampled only in IDLE.
REQ-005 Mode  input  2  00 byte MSB-first, 01 half MSB-first, 10 byte LSB-first, 11 half LSB-first.
REQ-006 D  input  32  word to unload (e.g. a Register32bit Q), captured on accepted start.
REQ-007 O  output  16  current beat; byte modes drive {8'h00, byte}.
REQ-008 OValid  output  1  O holds a valid beat.
REQ-009 ORdy  input  1  consumer accepts beat when OValid && ORdy at rising edge.
REQ-010 Busy  output  1  high from cycle after accepted start until last beat accepted.
REQ-011 Done  output  1  one-cycle pulse after last beat accepted.

Function
REQ-012 SHALL implement FSM IDLE -> SEND -> IDLE; Done is a registered pulse, not a state.
REQ-013 IDLE, E=1 at edge: SHALL capture D and Mode, load beat count (4 byte / 2 half), enter SEND.
REQ-014 SEND entry: OValid=1 and Busy=1 in first cycle after start edge (start-to-first-beat latency 1 cycle).
REQ-015 MSB-first order: byte D[31:24],[23:16],[15:8],[7:0]; half D[31:16],[15:0]. LSB-first: reverse order.
REQ-016 MSB-first byte order SHALL rebuild D when each beat is shift-loaded low-byte-in into a 32-bit register.
REQ-017 While OValid && !ORdy, O SHALL remain stable and OValid SHALL remain 1 (no retraction).
REQ-018 Each accepting edge SHALL present the next beat the following cycle; back-to-back ORdy=1 gives one beat per cycle.
REQ-019 On acceptance of last beat: next cycle OValid=0, Busy=0, Done=1, state IDLE.
REQ-020 E during SEND SHALL be ignored; D and Mode changes during SEND SHALL not affect the transfer.
REQ-021 E=1 in the Done cycle SHALL be accepted (IDLE); next transfer's first beat appears the following cycle.
REQ-022 O SHALL be 16'h0000 whenever OValid=0.

Reset
REQ-023 rst=0 at an edge SHALL force IDLE, O=0, OValid=0, Busy=0, Done=0, beat count 0, captured word 0.
REQ-024 Reset mid-transfer SHALL abort without Done; remaining beats discarded.
REQ-025 rst takes priority over E, ORdy and all other inputs.

Configuration
REQ-026 Macro WORD_SERIALIZER_PARITY_EN defined: extra output OPar (1 bit) = XOR of O[15:0], registered with O, 0 when OValid=0.
REQ-027 Macro undefined: OPar port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package SHALL hold Mode encodings, FSM state enum, beat-count constants (4, 2).
REQ-029 One sub-module natural: beat_counter (load/decrement, last-beat flag); datapath shifter stays in top.
REQ-030 Implementation SHALL be 120-400 lines RTL, no latches, single clock domain.

Verification
REQ-031 Reset rst=0 two cycles with E=1 -> all outputs 0, no transfer starts.
REQ-032 D=32'hA1B2C3D4, Mode=00, ORdy=1 -> O = 00A1,00B2,00C3,00D4 consecutive cycles, Done next cycle.
REQ-033 D=32'h12345678, Mode=11, ORdy toggling 0/1 -> O=5678 held while ORdy=0, then 1234; exactly 2 accepts, one Done.
REQ-034 Mode=01 transfer, D changed to 0 and E=1 mid-SEND -> output 1234,5678 unaffected; E ignored.
REQ-035 rst=0 after second byte of Mode=00 transfer -> next cycle OValid=0, Done never asserted, new E starts cleanly.
REQ-036 WORD_SERIALIZER_PARITY_EN defined, Mode=01, D=32'h0001_0003 -> OPar=1 on beat 0001, 0 on beat 0003.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// word_serializer_pkg
// Shared definitions for the word serializer: Mode encodings, FSM state
// enum, per-mode beat counts and the beat extract/shift helpers used by the
// datapath.
// -----------------------------------------------------------------------------
package word_serializer_pkg;

    // Mode[1] selects LSB-first order, Mode[0] selects 16-bit beats.
    typedef enum logic [1:0] {
        MODE_BYTE_MSB = 2'b00,
        MODE_HALF_MSB = 2'b01,
        MODE_BYTE_LSB = 2'b10,
        MODE_HALF_LSB = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic [2:0] BYTE_BEATS = 3'd4;
    localparam logic [2:0] HALF_BEATS = 3'd2;

    function automatic logic [2:0] beats_for(input mode_e m);
        beats_for = (m == MODE_HALF_MSB || m == MODE_HALF_LSB) ? HALF_BEATS : BYTE_BEATS;
    endfunction

    // The beat that leaves next always sits at the "exit" end of the word:
    // the top for MSB-first modes, the bottom for LSB-first modes.
    function automatic logic [15:0] beat_of(input logic [31:0] w, input mode_e m);
        case (m)
            MODE_BYTE_MSB: beat_of = {8'h00, w[31:24]};
            MODE_HALF_MSB: beat_of = w[31:16];
            MODE_BYTE_LSB: beat_of = {8'h00, w[7:0]};
            default:       beat_of = w[15:0];
        endcase
    endfunction

    // Discard the beat at the exit end so the following beat takes its place.
    function automatic logic [31:0] shift_out(input logic [31:0] w, input mode_e m);
        case (m)
            MODE_BYTE_MSB: shift_out = {w[23:0], 8'h00};
            MODE_HALF_MSB: shift_out = {w[15:0], 16'h0000};
            MODE_BYTE_LSB: shift_out = {8'h00, w[31:8]};
            default:       shift_out = {16'h0000, w[31:16]};
        endcase
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// -----------------------------------------------------------------------------
// word_serializer_if
// Request/beat bus of the word serializer.
//   E      start request          Mode  beat size / order
//   D      32-bit word to unload  O     current 16-bit beat
//   OValid O holds a valid beat   ORdy  consumer accepts the beat
//   Busy   transfer in progress   Done  one-cycle completion pulse
//   OPar   XOR of O (only with WORD_SERIALIZER_PARITY_EN defined)
// slave = serializer side, master = requester/consumer side.
// -----------------------------------------------------------------------------
interface word_serializer_if;
    logic        E;
    logic [1:0]  Mode;
    logic [31:0] D;
    logic [15:0] O;
    logic        OValid;
    logic        ORdy;
    logic        Busy;
    logic        Done;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic        OPar;
`endif

    modport slave (
        input  E, Mode, D, ORdy,
`ifdef WORD_SERIALIZER_PARITY_EN
        output OPar,
`endif
        output O, OValid, Busy, Done
    );

    modport master (
        output E, Mode, D, ORdy,
`ifdef WORD_SERIALIZER_PARITY_EN
        input  OPar,
`endif
        input  O, OValid, Busy, Done
    );
endinterface

// File: rtl/word_serializer_beat_counter.sv
// -----------------------------------------------------------------------------
// word_serializer_beat_counter
// Counts the beats still owed in a transfer.
//   clk, rst     clock, synchronous active-low reset
//   load         load load_value (start accepted)
//   load_value   number of beats in the transfer
//   dec          one beat accepted
//   last         the beat currently presented is the final one
// -----------------------------------------------------------------------------
module word_serializer_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] load_value,
    input  logic       dec,
    output logic       last
);
    logic [2:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= 3'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && count_reg != 3'd0) begin
            count_reg <= count_reg - 3'd1;
        end
    end

    assign last = (count_reg == 3'd1);
endmodule

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Unloads a captured 32-bit word as 4 byte beats or 2 half-word beats,
// MSB-first or LSB-first, over a valid/ready handshake.
//   clk   rising-edge clock
//   rst   synchronous active-low reset (0 = reset)
//   bus   word_serializer_if.slave (E, Mode, D, ORdy in; O, OValid, Busy,
//         Done out; OPar out when WORD_SERIALIZER_PARITY_EN is defined)
// Optional feature macro: WORD_SERIALIZER_PARITY_EN adds OPar = ^O.
// -----------------------------------------------------------------------------
module word_serializer
    import word_serializer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    word_serializer_if.slave  bus
);
    state_e      state_reg;
    logic [31:0] word_reg;      // beats not yet presented, next one at exit end
    mode_e       mode_reg;
    logic [15:0] o_reg;
    logic        ovalid_reg;
    logic        busy_reg;
    logic        done_reg;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic        opar_reg;
`endif

    mode_e       in_mode;
    logic [15:0] start_beat;
    logic [15:0] next_beat;
    logic [2:0]  start_count;
    logic        start;
    logic        accept;
    logic        last_beat;

    assign in_mode     = mode_e'(bus.Mode);
    assign start_beat  = beat_of(bus.D, in_mode);
    assign next_beat   = beat_of(word_reg, mode_reg);
    assign start_count = beats_for(in_mode);
    assign start       = (state_reg == ST_IDLE) && bus.E;
    assign accept      = (state_reg == ST_SEND) && bus.ORdy;

    word_serializer_beat_counter u_beat_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (start),
        .load_value (start_count),
        .dec        (accept),
        .last       (last_beat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            word_reg   <= 32'h0;
            mode_reg   <= MODE_BYTE_MSB;
            o_reg      <= 16'h0;
            ovalid_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            opar_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.E) begin
                        // First beat goes straight to O; the rest stays queued.
                        state_reg  <= ST_SEND;
                        word_reg   <= shift_out(bus.D, in_mode);
                        mode_reg   <= in_mode;
                        o_reg      <= start_beat;
                        ovalid_reg <= 1'b1;
                        busy_reg   <= 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
                        opar_reg   <= ^start_beat;
`endif
                    end
                end
                ST_SEND: begin
                    if (bus.ORdy) begin
                        if (last_beat) begin
                            state_reg  <= ST_IDLE;
                            o_reg      <= 16'h0;
                            ovalid_reg <= 1'b0;
                            busy_reg   <= 1'b0;
                            done_reg   <= 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
                            opar_reg   <= 1'b0;
`endif
                        end else begin
                            word_reg <= shift_out(word_reg, mode_reg);
                            o_reg    <= next_beat;
`ifdef WORD_SERIALIZER_PARITY_EN
                            opar_reg <= ^next_beat;
`endif
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.O      = o_reg;
    assign bus.OValid = ovalid_reg;
    assign bus.Busy   = busy_reg;
    assign bus.Done   = done_reg;
`ifdef WORD_SERIALIZER_PARITY_EN
    assign bus.OPar   = opar_reg;
`endif
endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
// Self-checking bench for word_serializer: directed cases plus randomized
// transfers, compared against a beat-list model built from the word and mode.
// Checks OPar as well when WORD_SERIALIZER_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_word_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    word_serializer_if bus();

    word_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected beats in presentation order, straight from the ordering rules.
    task automatic build_model(input logic [31:0] d, input logic [1:0] m);
        int n;
        int w;
        int idx;
        n = m[0] ? 2 : 4;
        w = m[0] ? 16 : 8;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            idx = m[1] ? i : (n - 1 - i);
            exp_q.push_back(16'((d >> (w * idx)) & ((1 << w) - 1)));
        end
    endtask

    task automatic check_idle(input string tag, input logic done_exp);
        check_val({tag, " ovalid"}, bus.OValid, 0);
        check_val({tag, " o"}, bus.O, 0);
        check_val({tag, " busy"}, bus.Busy, 0);
        check_val({tag, " done"}, bus.Done, done_exp);
`ifdef WORD_SERIALIZER_PARITY_EN
        check_val({tag, " opar"}, bus.OPar, 0);
`endif
    endtask

    // Called just after a negedge with the DUT idle (or in its Done cycle).
    task automatic start_xfer(input logic [31:0] d, input logic [1:0] m);
        bus.E    = 1'b1;
        bus.D    = d;
        bus.Mode = m;
        @(negedge clk);
        bus.E = 1'b0;
        build_model(d, m);
        $display("start D=%h Mode=%0d beats=%0d", d, m, exp_q.size());
    endtask

    // rmode: 0 ORdy always 1, 1 ORdy toggles starting at 0, 2 random.
    // scramble: 0 none, 1 random E/D/Mode, 2 E=1 and D=0.
    // Returns in the Done cycle, after checking it.
    task automatic drain(input logic [31:0] d, input logic [1:0] m, input int rmode,
                         input int scramble, input string tag);
        int cyc;
        int accepts;
        logic r;
        logic [15:0] o_seen;
        logic [31:0] rebuilt;
        cyc = 0;
        accepts = 0;
        rebuilt = 32'h0;
        while (exp_q.size() > 0 && cyc < 100) begin
            check_val({tag, " ovalid"}, bus.OValid, 1);
            check_val({tag, " o"}, bus.O, exp_q[0]);
            check_val({tag, " busy"}, bus.Busy, 1);
            check_val({tag, " done"}, bus.Done, 0);
`ifdef WORD_SERIALIZER_PARITY_EN
            check_val({tag, " opar"}, bus.OPar, ^exp_q[0]);
`endif
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 2) == 1;
                default: r = $urandom_range(0, 3) != 0;
            endcase
            bus.ORdy = r;
            if (scramble == 1) begin
                bus.E    = 1'($urandom_range(0, 1));
                bus.D    = $urandom;
                bus.Mode = 2'($urandom_range(0, 3));
            end else if (scramble == 2) begin
                bus.E = 1'b1;
                bus.D = 32'h0;
            end
            o_seen = bus.O;
            @(negedge clk);
            cyc++;
            if (r) begin
                $display("%s beat O=%h", tag, o_seen);
                rebuilt = {rebuilt[23:0], o_seen[7:0]};
                accepts++;
                void'(exp_q.pop_front());
            end
        end
        if (exp_q.size() != 0)
            check_val({tag, " timeout beats_left"}, exp_q.size(), 0);
        bus.E = 1'b0;
        check_idle({tag, " donecyc"}, 1'b1);
        if (m == 2'b00)
            check_val({tag, " rebuild"}, rebuilt, d);
        check_val({tag, " accepts"}, accepts, m[0] ? 2 : 4);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  m;
        bus.E = 1'b0; bus.D = 32'h0; bus.Mode = 2'b00; bus.ORdy = 1'b0;

        // Reset held two cycles with E=1: nothing may start.
        rst = 1'b0; bus.E = 1'b1; bus.D = 32'hFFFF_FFFF; bus.ORdy = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset", 1'b0);
        bus.E = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_idle("post_reset", 1'b0);

        // Byte MSB-first, consumer always ready.
        start_xfer(32'hA1B2C3D4, 2'b00);
        drain(32'hA1B2C3D4, 2'b00, 0, 0, "byte_msb");
        @(negedge clk);
        check_idle("byte_msb_after", 1'b0);

        // Half LSB-first with back-pressure.
        start_xfer(32'h12345678, 2'b11);
        drain(32'h12345678, 2'b11, 1, 0, "half_lsb_bp");
        @(negedge clk);
        check_idle("half_lsb_after", 1'b0);

        // Half MSB-first with D=0 and E=1 during SEND.
        start_xfer(32'h12345678, 2'b01);
        drain(32'h12345678, 2'b01, 1, 2, "half_msb_ign");
        @(negedge clk);
        check_idle("half_msb_after", 1'b0);

        // Reset after the second byte: abort with no Done.
        start_xfer(32'hCAFEF00D, 2'b00);
        bus.ORdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_val("abort pre o", bus.O, exp_q[0]);
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        check_val("abort third o", bus.O, exp_q[0]);
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort", 1'b0);
        rst = 1'b1;
        bus.ORdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("abort_quiet", 1'b0);
        end
        start_xfer(32'h0BADBEEF, 2'b10);
        drain(32'h0BADBEEF, 2'b10, 0, 0, "after_abort");
        @(negedge clk);
        check_idle("after_abort_idle", 1'b0);

        // Parity pattern (OPar 1 then 0 when the feature is built in).
        start_xfer(32'h0001_0003, 2'b01);
        drain(32'h0001_0003, 2'b01, 0, 0, "parity");

        // Randomized transfers, some started in the Done cycle.
        for (int t = 0; t < 40; t++) begin
            d = $urandom;
            m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check_idle("rnd_gap", 1'b0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            start_xfer(d, m);
            drain(d, m, 2, 1, "rnd");
        end
        @(negedge clk);
        check_idle("final", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
